// File: rtl/i2s_tx_if.sv
// i2s_tx_if: valid/ready sample handshake into the I2S transmitter.
// master drives data/valid, slave returns ready.
interface i2s_tx_if #(
    parameter int width_p = 24
);
    logic [width_p-1:0] data;
    logic               valid;
    logic               ready;

    modport master (
        output data,
        output valid,
        input  ready
    );

    modport slave (
        input  data,
        input  valid,
        output ready
    );
endinterface

// File: rtl/i2s_tx.sv
// i2s_tx: I2S transmitter, one sample per frame on both channels.
// Option: I2S_TX_ZERO_ON_UNDERRUN_EN sends silence on underrun.
module i2s_tx #(
    parameter int width_p      = 24,
    parameter int slot_width_p = 32,
    parameter int sclk_div_p   = 4
) (
    input  logic    clk_i,
    input  logic    reset_i,
    i2s_tx_if.slave in_if,
    output logic    sclk_o,
    output logic    lrclk_o,
    output logic    sdata_o,
    output logic    underrun_o
);
    localparam int frame_bits_lp = 2 * slot_width_p;
    localparam int dw_lp =
        (sclk_div_p > 1) ? $clog2(sclk_div_p) : 1;
    localparam int bw_lp = $clog2(frame_bits_lp);

    localparam logic [dw_lp-1:0] div_last_lp =
        dw_lp'(sclk_div_p - 1);
    localparam logic [bw_lp-1:0] bit_last_lp =
        bw_lp'(frame_bits_lp - 1);
    localparam logic [bw_lp-1:0] slot_lp =
        bw_lp'(slot_width_p);

    logic [dw_lp-1:0]   div_q;
    logic [bw_lp-1:0]   bit_q;
    logic [bw_lp-1:0]   bit_nxt;
    logic [bw_lp-1:0]   slot_idx;
    logic               sclk_q;
    logic               lrclk_q;
    logic               sdata_q;
    logic               underrun_q;
    logic               ready_q;
    logic               full_q;
    logic               full_nxt;
    logic               div_tc;
    logic               fall;
    logic               frame_start;
    logic               xfer;
    logic [width_p-1:0] hold_q;
    logic [width_p-1:0] play_q;
    logic [width_p-1:0] shift_q;
    logic [width_p-1:0] load_val;
    logic [width_p-1:0] slot_val;

    assign div_tc      = (div_q == div_last_lp);
    assign fall        = div_tc & sclk_q;
    assign bit_nxt     = (bit_q == bit_last_lp) ? '0 : bit_q + 1'b1;
    assign frame_start = fall & (bit_q == bit_last_lp);
    assign slot_idx    = (bit_nxt >= slot_lp) ? bit_nxt - slot_lp
                                              : bit_nxt;
    assign xfer        = in_if.valid & ready_q;
    assign full_nxt    = (full_q & ~frame_start) | xfer;

    // play_q also serves as the replay copy of the last sample
`ifdef I2S_TX_ZERO_ON_UNDERRUN_EN
    assign load_val = full_q ? hold_q : '0;
`else
    assign load_val = full_q ? hold_q : play_q;
`endif

    assign slot_val = frame_start ? load_val : play_q;

    assign in_if.ready = ready_q;
    assign sclk_o      = sclk_q;
    assign lrclk_o     = lrclk_q;
    assign sdata_o     = sdata_q;
    assign underrun_o  = underrun_q;

    // divide clk_i down to the bit clock
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            div_q  <= '0;
            sclk_q <= 1'b0;
        end else if (div_tc) begin
            div_q  <= '0;
            sclk_q <= ~sclk_q;
        end else begin
            div_q <= div_q + 1'b1;
        end
    end

    // frame position, word select and MSB-first serializer
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            bit_q   <= bit_last_lp;
            lrclk_q <= 1'b0;
            sdata_q <= 1'b0;
            shift_q <= '0;
            play_q  <= '0;
        end else if (fall) begin
            bit_q   <= bit_nxt;
            lrclk_q <= (bit_nxt >= slot_lp);
            if (frame_start) begin
                play_q <= load_val;
            end
            if (slot_idx == '0) begin
                sdata_q <= 1'b0;
                shift_q <= slot_val;
            end else begin
                sdata_q <= shift_q[width_p-1];
                shift_q <= {shift_q[width_p-2:0], 1'b0};
            end
        end
    end

    // one-entry holding register and underrun flag
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            full_q     <= 1'b0;
            ready_q    <= 1'b0;
            hold_q     <= '0;
            underrun_q <= 1'b0;
        end else begin
            full_q     <= full_nxt;
            ready_q    <= ~full_nxt;
            underrun_q <= frame_start & ~full_q;
            if (xfer) begin
                hold_q <= in_if.data;
            end
        end
    end
endmodule

// File: tb/tb_i2s_tx.sv
// tb_i2s_tx: scenario tasks checked against a timing-arithmetic
// reference model of the I2S frame and sample handshake.
module tb_i2s_tx;
    localparam int W     = 24;
    localparam int SW    = 32;
    localparam int D     = 4;
    localparam int FRAME = 2 * SW * 2 * D;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic sclk;
    logic lr;
    logic sd;
    logic ur;

    i2s_tx_if #(.width_p(W)) bus ();

    i2s_tx #(
        .width_p(W),
        .slot_width_p(SW),
        .sclk_div_p(D)
    ) dut (
        .clk_i(clk),
        .reset_i(reset),
        .in_if(bus),
        .sclk_o(sclk),
        .lrclk_o(lr),
        .sdata_o(sd),
        .underrun_o(ur)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // reference model state
    int         n = 0;
    bit         m_full = 0;
    bit         m_ready = 0;
    logic [W-1:0] m_hold = '0;
    logic [W-1:0] m_last = '0;
    logic [W-1:0] m_frame = '0;
    logic [4:0] exp_v = '0;
    logic [4:0] obs;

    assign obs = {bus.ready, sclk, lr, sd, ur};

    bit m_fs;
    bit m_was_full;
    bit m_xfer;
    int m_k;
    int m_b;
    int m_s;
    logic [W-1:0] m_t;
    logic e_sclk;
    logic e_lr;
    logic e_sd;

    // expected outputs from elapsed cycles since reset release
    always @(posedge clk) begin
        if (reset) begin
            n       = 0;
            m_full  = 0;
            m_ready = 0;
            m_last  = '0;
            m_frame = '0;
            exp_v   = '0;
        end else begin
            m_xfer = bus.valid && m_ready;
            n = n + 1;
            m_fs = (n % FRAME) == 2 * D;
            m_was_full = m_full;
            if (m_fs) begin
                if (m_full) begin
                    m_frame = m_hold;
                    m_last  = m_hold;
                    m_full  = 0;
                end else begin
`ifdef I2S_TX_ZERO_ON_UNDERRUN_EN
                    m_frame = '0;
`else
                    m_frame = m_last;
`endif
                end
            end
            if (m_xfer) begin
                m_hold = bus.data;
                m_full = 1;
            end
            m_ready = !m_full;
            e_sclk = ((n / D) % 2) == 1;
            e_lr = 1'b0;
            e_sd = 1'b0;
            if (n >= 2 * D) begin
                m_k = n / (2 * D);
                m_b = (m_k - 1) % (2 * SW);
                e_lr = (m_b >= SW);
                m_s = m_b % SW;
                if (m_s >= 1 && m_s <= W) begin
                    m_t = m_frame >> (W - m_s);
                    e_sd = m_t[0];
                end
            end
            exp_v = {m_ready, e_sclk, e_lr, e_sd,
                     m_fs && !m_was_full};
        end
    end

    task automatic do_reset(input int cyc);
        @(posedge clk);
        #1;
        reset = 1'b1;
        bus.valid = 1'b0;
        repeat (cyc) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic push(input logic [W-1:0] d);
        int waited;
        waited = 0;
        bus.valid = 1'b1;
        bus.data  = d;
        forever begin
            @(negedge clk);
            if (m_ready) break;
            waited++;
            if (waited > 3 * FRAME) begin
                checks++;
                failures++;
                $display("FAIL push_timeout got=%0d want<=%0d",
                         waited, 3 * FRAME);
                break;
            end
        end
        @(posedge clk);
        #1;
        bus.valid = 1'b0;
    endtask

    task automatic test_reset();
        @(posedge clk);
        #1;
        reset = 1'b1;
        bus.valid = 1'b0;
        repeat (3) begin
            @(negedge clk);
            checks++;
            if (obs !== 5'b0) begin
                failures++;
                $display("FAIL reset_hold got=%b want=%b",
                         obs, 5'b0);
            end
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (FRAME + 2 * 2 * D) begin
            @(negedge clk);
            checks++;
            if (obs !== exp_v) begin
                failures++;
                $display("FAIL reset n=%0d got=%b want=%b",
                         n, obs, exp_v);
            end
        end
    endtask

    task automatic test_single();
        do_reset(2);
        fork
            push(24'hA5F00F);
            repeat (2 * FRAME + 32) begin
                @(negedge clk);
                checks++;
                if (obs !== exp_v) begin
                    failures++;
                    $display("FAIL single n=%0d got=%b want=%b",
                             n, obs, exp_v);
                end
            end
        join
    endtask

    task automatic test_back_to_back();
        fork
            begin
                push(24'h000001);
                push(24'h000002);
                push(24'h000003);
            end
            repeat (4 * FRAME) begin
                @(negedge clk);
                checks++;
                if (obs !== exp_v) begin
                    failures++;
                    $display("FAIL b2b n=%0d got=%b want=%b",
                             n, obs, exp_v);
                end
            end
        join
    endtask

    task automatic test_underrun();
        fork
            push(24'h123456);
            repeat (3 * FRAME) begin
                @(negedge clk);
                checks++;
                if (obs !== exp_v) begin
                    failures++;
                    $display("FAIL underrun n=%0d got=%b want=%b",
                             n, obs, exp_v);
                end
            end
        join
    endtask

    task automatic test_sign_extreme();
        fork
            push(24'h800000);
            repeat (2 * FRAME) begin
                @(negedge clk);
                checks++;
                if (obs !== exp_v) begin
                    failures++;
                    $display("FAIL sign n=%0d got=%b want=%b",
                             n, obs, exp_v);
                end
            end
        join
    endtask

    task automatic test_midframe_reset();
        do_reset(2);
        fork
            begin
                repeat (100) @(posedge clk);
                #1;
                push(24'h0F0F0F);
                do begin
                    @(posedge clk);
                    #1;
                end while (n < 330);
                reset = 1'b1;
                repeat (2) @(posedge clk);
                #1;
                reset = 1'b0;
                push(24'h3C5A96);
            end
            repeat (340 + 2 * FRAME) begin
                @(negedge clk);
                checks++;
                if (obs !== exp_v) begin
                    failures++;
                    $display("FAIL midreset n=%0d got=%b want=%b",
                             n, obs, exp_v);
                end
            end
        join
    endtask

    task automatic test_random();
        fork
            begin
                for (int i = 0; i < 6000; i++) begin
                    @(posedge clk);
                    #1;
                    bus.data = W'($urandom);
                    if (i < 3000)
                        bus.valid = ($urandom_range(0, 599) == 0);
                    else
                        bus.valid = ($urandom_range(0, 1) == 1);
                end
                bus.valid = 1'b0;
            end
            repeat (6000) begin
                @(negedge clk);
                checks++;
                if (obs !== exp_v) begin
                    failures++;
                    $display("FAIL random n=%0d got=%b want=%b",
                             n, obs, exp_v);
                end
            end
        join
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.valid = 1'b0;
        bus.data  = '0;
        test_reset();
        test_single();
        test_back_to_back();
        test_underrun();
        test_sign_extreme();
        test_midframe_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d",
                 checks, failures);
        $finish;
    end
endmodule
